player_action: RTL
==================

Name: player_action

Overview:
- Consumes the object code that check_in_front reports for the cell the player faces, and executes the player's grab/chop action on it.
- Tracks the item held by the player.
- Computes the faced cell's coordinates and issues single-cycle write requests to the object-grid owner.
- Runs the chopping progress counter for whole onions.

Parameters:
- CHOP_TICKS, 60, frame ticks chop_in must be held to turn ONION_WHOLE into ONION_CHOPPED
- GRID_W, 13, grid columns (x = 0..12)
- GRID_H, 8, grid rows (y = 0..7)

Ports:
- clk_in  input  1  system clock
- rst_in_n  input  1  asynchronous active-low reset
- frame_tick_in  input  1  one-cycle pulse per video frame
- grab_in  input  1  one-cycle pulse, grab/place button
- chop_in  input  1  level, chop button held
- grid_x  input  4  player cell x
- grid_y  input  3  player cell y
- player_direction  input  2  LEFT=0, RIGHT=1, UP=2, DOWN=3
- obj_front  input  4  object code in faced cell (from check_in_front)
- grid_we  output  1  one-cycle write strobe to object grid
- grid_wx  output  4  write column
- grid_wy  output  3  write row
- grid_wobj  output  4  object code to write
- held_obj  output  4  item carried by player (G_EMPTY if none)
- chop_progress  output  8  ticks accumulated on current chop, saturates at CHOP_TICKS
- busy  output  1  high while not IDLE

Behaviour:
- Reset (async, rst_in_n low): state IDLE, held_obj=G_EMPTY, grid_we=0, grid_wx=0, grid_wy=0, grid_wobj=0, chop_progress=0, busy=0. Reset mid-operation aborts without a write.
- Target cell:
  - LEFT: x-1; RIGHT: x+1; UP: y-1; DOWN: y+1.
  - Target is invalid when x=0 LEFT, x=GRID_W-1 RIGHT, y=0 UP, or y=GRID_H-1 DOWN.
  - An invalid target makes every action a no-op.
- States: IDLE, EVAL, WRITE, CHOP.
- IDLE:
  - grab_in=1 → latch target, obj_front and held_obj; go to EVAL.
  - Else if chop_in=1, held_obj=G_EMPTY, obj_front=G_ONION_WHOLE and target valid → latch target; go to CHOP.
  - grab_in has priority over chop_in when both are asserted.
- EVAL: decide using the latched values (first matching rule wins). Any matching rule → WRITE; otherwise → IDLE with no write.
  1. held EMPTY, front ∈ {ONION_WHOLE, ONION_CHOPPED, BOWL_EMPTY, BOWL_FULL, EXTINGUISHER} → wobj=EMPTY, new held=front.
  2. held ONION_CHOPPED, front POT_EMPTY → wobj=POT_RAW, held=EMPTY.
  3. held BOWL_EMPTY, front POT_COOKED → wobj=POT_EMPTY, held=BOWL_FULL.
  4. held EXTINGUISHER, front POT_FIRE → wobj=POT_EMPTY. front FIRE → wobj=EMPTY. held unchanged.
  5. held non-EMPTY, front EMPTY → wobj=held, held=EMPTY.
- WRITE: grid_we=1 for exactly one cycle with wx/wy/wobj; held_obj updates on the same edge; then → IDLE.
- Latency: grab_in at edge N → grid_we high during cycle N+2. grab_in pulses arriving while busy are dropped.
- CHOP:
  - Each frame_tick_in while chop_in=1 increments chop_progress.
  - If chop_in=0 or obj_front≠ONION_WHOLE while in CHOP → chop_progress=0, → IDLE, no write.
  - On reaching CHOP_TICKS → WRITE with wobj=ONION_CHOPPED, held unchanged; chop_progress clears on the return to IDLE.
  - grab_in is ignored during CHOP.
- Object codes are 4-bit. Codes 11..15 are treated as non-interactive (no-op).

Decomposition:
- Shared package overcooked_pkg holds:
  - object codes G_EMPTY..G_EXTINGUISHER (0..10)
  - direction codes LEFT/RIGHT/UP/DOWN
  - grid dimensions
  - state enum
- check_in_front should migrate to the same package.
- One natural sub-module: target_cell, a combinational block (grid_x, grid_y, direction → tgt_x, tgt_y, tgt_valid). It is shared with check_in_front so both agree on the faced cell.

Test Plan:
- Pick-up: player (1,2) facing LEFT, obj_front=ONION_WHOLE (cell (0,2)), held EMPTY, grab pulse → two cycles later grid_we=1, wx=0, wy=2, wobj=0; held_obj=1.
- Edge no-op: player (0,2) facing LEFT, grab → no grid_we for 5 cycles; held_obj unchanged; busy back low after 2 cycles.
- Pot fill: held ONION_CHOPPED, player (9,1) facing UP, obj_front=POT_EMPTY, grab → grid_we, wx=9, wy=0, wobj=6; held_obj=0.
- Serve: held BOWL_EMPTY, player (11,6) facing RIGHT, obj_front=POT_COOKED, grab → wx=12, wy=6, wobj=5; held_obj=4.
- Chop:
  - CHOP_TICKS=4, held EMPTY, obj_front=ONION_WHOLE, chop_in high across 4 frame ticks → chop_progress 1,2,3,4, then one grid_we with wobj=2.
  - Repeat, dropping chop_in after 2 ticks → progress returns to 0, no write.
- Priority/reset:
  - grab and chop asserted in the same cycle → grab path taken.
  - Asserting rst_in_n low during EVAL → no grid_we; all outputs at their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/overcooked_pkg.sv
// Shared definitions for the kitchen game: object codes, directions, grid size,
// player-action FSM states and the result of one grab/place decision.
package overcooked_pkg;

  localparam logic [3:0] G_EMPTY         = 4'd0;
  localparam logic [3:0] G_ONION_WHOLE   = 4'd1;
  localparam logic [3:0] G_ONION_CHOPPED = 4'd2;
  localparam logic [3:0] G_BOWL_EMPTY    = 4'd3;
  localparam logic [3:0] G_BOWL_FULL     = 4'd4;
  localparam logic [3:0] G_POT_EMPTY     = 4'd5;
  localparam logic [3:0] G_POT_RAW       = 4'd6;
  localparam logic [3:0] G_POT_COOKED    = 4'd7;
  localparam logic [3:0] G_POT_FIRE      = 4'd8;
  localparam logic [3:0] G_FIRE          = 4'd9;
  localparam logic [3:0] G_EXTINGUISHER  = 4'd10;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int GRID_W_DEF = 13;
  localparam int GRID_H_DEF = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_WRITE, ST_CHOP} pa_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] wobj;
    logic [3:0] held;
  } action_t;

endpackage

// File: rtl/player_action_if.sv
// Single-cycle write port into the object grid owner.
interface player_action_if;
  logic       grid_we;
  logic [3:0] grid_wx;
  logic [2:0] grid_wy;
  logic [3:0] grid_wobj;

  modport master (output grid_we, grid_wx, grid_wy, grid_wobj);
  modport slave  (input  grid_we, grid_wx, grid_wy, grid_wobj);
endinterface

// File: rtl/player_action_target_cell.sv
// Faced-cell calculator shared with check_in_front so both agree on the target.
module target_cell
  import overcooked_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [3:0] grid_x,
  input  logic [2:0] grid_y,
  input  logic [1:0] direction,
  output logic [3:0] tgt_x,
  output logic [2:0] tgt_y,
  output logic       tgt_valid
);
  localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
  localparam logic [2:0] Y_MAX = 3'(GRID_H - 1);

  always_comb begin
    tgt_x     = grid_x;
    tgt_y     = grid_y;
    tgt_valid = 1'b0;
    case (direction)
      DIR_LEFT: begin
        tgt_x     = grid_x - 4'd1;
        tgt_valid = (grid_x != 4'd0);
      end
      DIR_RIGHT: begin
        tgt_x     = grid_x + 4'd1;
        tgt_valid = (grid_x < X_MAX);
      end
      DIR_UP: begin
        tgt_y     = grid_y - 3'd1;
        tgt_valid = (grid_y != 3'd0);
      end
      DIR_DOWN: begin
        tgt_y     = grid_y + 3'd1;
        tgt_valid = (grid_y < Y_MAX);
      end
      default: tgt_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/player_action.sv
// Executes the player's grab/place and chop actions on the faced cell, tracks
// the held item and issues one-cycle writes to the object grid.
module player_action
  import overcooked_pkg::*;
#(
  parameter int CHOP_TICKS = 60,
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        frame_tick_in,
  input  logic        grab_in,
  input  logic        chop_in,
  input  logic [3:0]  grid_x,
  input  logic [2:0]  grid_y,
  input  logic [1:0]  player_direction,
  input  logic [3:0]  obj_front,
  player_action_if.master grid,
  output logic [3:0]  held_obj,
  output logic [7:0]  chop_progress,
  output logic        busy
);
  localparam logic [7:0] CHOP_MAX = 8'(CHOP_TICKS);

  logic [3:0] tgt_x;
  logic [2:0] tgt_y;
  logic       tgt_valid;

  pa_state_t  state, state_nxt;
  logic [3:0] lat_x, lat_front, lat_held;
  logic [2:0] lat_y;
  logic       lat_valid;
  logic       wr_go;
  logic [3:0] wr_obj, held_nxt;
  logic [7:0] prog_nxt;
  action_t    act;

  target_cell #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_target_cell (
    .grid_x    (grid_x),
    .grid_y    (grid_y),
    .direction (player_direction),
    .tgt_x     (tgt_x),
    .tgt_y     (tgt_y),
    .tgt_valid (tgt_valid)
  );

  // First matching rule wins; codes above G_EXTINGUISHER never match.
  function automatic action_t eval_action(input logic [3:0] held, input logic [3:0] front);
    action_t a;
    a = '{hit: 1'b1, wobj: G_EMPTY, held: held};
    if (held == G_EMPTY && (front inside {G_ONION_WHOLE, G_ONION_CHOPPED, G_BOWL_EMPTY,
                                          G_BOWL_FULL, G_EXTINGUISHER}))
      a.held = front;
    else if (held == G_ONION_CHOPPED && front == G_POT_EMPTY)
      a = '{hit: 1'b1, wobj: G_POT_RAW, held: G_EMPTY};
    else if (held == G_BOWL_EMPTY && front == G_POT_COOKED)
      a = '{hit: 1'b1, wobj: G_POT_EMPTY, held: G_BOWL_FULL};
    else if (held == G_EXTINGUISHER && front == G_POT_FIRE)
      a.wobj = G_POT_EMPTY;
    else if (held == G_EXTINGUISHER && front == G_FIRE)
      a.wobj = G_EMPTY;
    else if (held != G_EMPTY && front == G_EMPTY)
      a = '{hit: 1'b1, wobj: held, held: G_EMPTY};
    else
      a.hit = 1'b0;
    return a;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= CHOP_MAX) ? CHOP_MAX : v + 8'd1;
  endfunction

  assign act  = eval_action(lat_held, lat_front);
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    wr_obj    = G_EMPTY;
    held_nxt  = held_obj;
    prog_nxt  = chop_progress;
    case (state)
      ST_IDLE: begin
        if (grab_in)
          state_nxt = ST_EVAL;
        else if (chop_in && held_obj == G_EMPTY && obj_front == G_ONION_WHOLE && tgt_valid)
          state_nxt = ST_CHOP;
      end
      ST_EVAL: begin
        if (lat_valid && act.hit) begin
          state_nxt = ST_WRITE;
          wr_go     = 1'b1;
          wr_obj    = act.wobj;
          held_nxt  = act.held;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_IDLE;
        prog_nxt  = '0;
      end
      ST_CHOP: begin
        if (!chop_in || obj_front != G_ONION_WHOLE) begin
          state_nxt = ST_IDLE;
          prog_nxt  = '0;
        end else if (frame_tick_in) begin
          prog_nxt = sat_inc(chop_progress);
          if (prog_nxt == CHOP_MAX) begin
            state_nxt = ST_WRITE;
            wr_go     = 1'b1;
            wr_obj    = G_ONION_CHOPPED;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state          <= ST_IDLE;
      held_obj       <= G_EMPTY;
      chop_progress  <= '0;
      grid.grid_we   <= 1'b0;
      grid.grid_wx   <= '0;
      grid.grid_wy   <= '0;
      grid.grid_wobj <= '0;
    end else begin
      state         <= state_nxt;
      held_obj      <= held_nxt;
      chop_progress <= prog_nxt;
      grid.grid_we  <= wr_go;
      if (wr_go) begin
        grid.grid_wx   <= lat_x;
        grid.grid_wy   <= lat_y;
        grid.grid_wobj <= wr_obj;
      end
    end
  end

  // Snapshot of the request, refreshed every idle cycle so the value taken on
  // the IDLE->EVAL/CHOP edge is the one acted on.
  always_ff @(posedge clk_in) begin
    if (state == ST_IDLE) begin
      lat_x     <= tgt_x;
      lat_y     <= tgt_y;
      lat_valid <= tgt_valid;
      lat_front <= obj_front;
      lat_held  <= held_obj;
    end
  end
endmodule
